line_buffer_mc_stride: RTL and testbench

Parametrised successor of the single-channel 5x5 window generator. It accepts a raster-order pixel stream of CH packed channels and buffers KY-1 full lines plus the current line. It emits a registered KYxKX multi-channel window at a programmable stride, with output coordinates, an end-of-frame flag and start-of-frame resynchronisation. It sits between the pixel source and the convolution engine.

---
 rtl/line_buffer_mc_stride.sv | 148 ++++++++++++++
 tb/tb_line_buffer_mc_stride.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_mc_stride.sv
// Strided KYxKX multi-channel window generator over a raster pixel stream.
// KY-1 line memories plus a KX-column shift register feed a registered window output.
module line_buffer_mc_stride #(
   parameter  int I_F_BW = 8,
   parameter  int CH     = 1,
   parameter  int IX     = 28,
   parameter  int IY     = 28,
   parameter  int KX     = 5,
   parameter  int KY     = 5,
   parameter  int STRIDE = 1,
   localparam int OX     = (IX - KX) / STRIDE + 1,
   localparam int OY     = (IY - KY) / STRIDE + 1,
   localparam int OXW    = (OX > 1) ? $clog2(OX) : 1,
   localparam int OYW    = (OY > 1) ? $clog2(OY) : 1,
   localparam int PW     = CH * I_F_BW
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      i_in_valid,
   input  logic                      i_sof,
   input  logic [PW-1:0]             i_in_pixel,
   output logic                      o_window_valid,
   output logic [KX*KY*PW-1:0]       o_window,
   output logic [OXW-1:0]            o_out_x,
   output logic [OYW-1:0]            o_out_y,
   output logic                      o_last
);

   localparam int XW = $clog2(IX);
   localparam int YW = $clog2(IY);
   localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

   logic [XW-1:0]  x_q, x_d, cur_x;
   logic [YW-1:0]  y_q, y_d, cur_y;
   logic [SW-1:0]  xph_q, xph_d, cur_xph;
   logic [SW-1:0]  yph_q, yph_d, cur_yph;
   logic [OXW-1:0] ox_q, ox_d, cur_ox;
   logic [OYW-1:0] oy_q, oy_d, cur_oy;
   logic           col_hit, row_hit, fire, last_d;
   logic [KX*KY*PW-1:0] win_d;

   logic [PW-1:0] line_q   [KY-1][IX];
   logic [PW-1:0] cols_q   [KX-1][KY];
   logic [PW-1:0] cur_cols [KX][KY];

   always_comb begin
      // i_sof overrides the stored position so the current pixel is (0,0)
      cur_x   = i_sof ? '0 : x_q;
      cur_y   = i_sof ? '0 : y_q;
      cur_xph = i_sof ? '0 : xph_q;
      cur_yph = i_sof ? '0 : yph_q;
      cur_ox  = i_sof ? '0 : ox_q;
      cur_oy  = i_sof ? '0 : oy_q;

      col_hit = (cur_x >= XW'(KX - 1)) && (cur_xph == '0);
      row_hit = (cur_y >= YW'(KY - 1)) && (cur_yph == '0);
      fire    = i_in_valid && col_hit && row_hit;
      last_d  = fire && (cur_ox == OXW'(OX - 1)) && (cur_oy == OYW'(OY - 1));

      x_d   = x_q;
      y_d   = y_q;
      xph_d = xph_q;
      yph_d = yph_q;
      ox_d  = ox_q;
      oy_d  = oy_q;
      if (i_in_valid) begin
         x_d   = cur_x + 1'b1;
         y_d   = cur_y;
         xph_d = cur_xph;
         yph_d = cur_yph;
         ox_d  = cur_ox;
         oy_d  = cur_oy;
         if (cur_x >= XW'(KX - 1)) begin
            xph_d = (cur_xph == SW'(STRIDE - 1)) ? '0 : cur_xph + 1'b1;
            if (col_hit) ox_d = cur_ox + 1'b1;
         end
         if (cur_x == XW'(IX - 1)) begin
            x_d   = '0;
            xph_d = '0;
            ox_d  = '0;
            if (cur_y == YW'(IY - 1)) begin
               y_d   = '0;
               yph_d = '0;
               oy_d  = '0;
            end else begin
               y_d = cur_y + 1'b1;
               if (cur_y >= YW'(KY - 1)) begin
                  yph_d = (cur_yph == SW'(STRIDE - 1)) ? '0 : cur_yph + 1'b1;
                  if (row_hit) oy_d = cur_oy + 1'b1;
               end
            end
         end
      end

      // column KX-1 is the column being written this cycle, oldest line on top
      for (int unsigned wx = 0; wx < KX - 1; wx++)
         cur_cols[wx] = cols_q[wx];
      for (int unsigned wy = 0; wy < KY - 1; wy++)
         cur_cols[KX-1][wy] = line_q[wy][cur_x];
      cur_cols[KX-1][KY-1] = i_in_pixel;

      win_d = '0;
      for (int unsigned wy = 0; wy < KY; wy++)
         for (int unsigned wx = 0; wx < KX; wx++)
            win_d[(wy*KX + wx)*PW +: PW] = cur_cols[wx][wy];
   end

   always_ff @(posedge clk) begin
      if (i_in_valid) begin
         for (int unsigned n = 0; n + 1 < KY - 1; n++)
            line_q[n][cur_x] <= line_q[n+1][cur_x];
         line_q[KY-2][cur_x] <= i_in_pixel;
         for (int unsigned i = 0; i < KX - 1; i++)
            cols_q[i] <= cur_cols[i+1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q            <= '0;
         y_q            <= '0;
         xph_q          <= '0;
         yph_q          <= '0;
         ox_q           <= '0;
         oy_q           <= '0;
         o_window_valid <= 1'b0;
         o_last         <= 1'b0;
         o_window       <= '0;
         o_out_x        <= '0;
         o_out_y        <= '0;
      end else begin
         x_q            <= x_d;
         y_q            <= y_d;
         xph_q          <= xph_d;
         yph_q          <= yph_d;
         ox_q           <= ox_d;
         oy_q           <= oy_d;
         o_window_valid <= fire;
         o_last         <= last_d;
         if (fire) begin
            o_window <= win_d;
            o_out_x  <= cur_ox;
            o_out_y  <= cur_oy;
         end
      end
   end

endmodule

// File: tb/tb_line_buffer_mc_stride.sv
// Bench for line_buffer_mc_stride: three 6x6/3x3 instances (stride 1, stride 2, 3 channels)
// compared each cycle against an image-array reference model, plus fixed pulse tables.
module tb_line_buffer_mc_stride;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic in_valid = 1'b0;
   logic sof = 1'b0;
   logic [7:0]  pix_a = 8'd0;
   logic [23:0] pix_c;
   assign pix_c = {pix_a + 8'd128, pix_a + 8'd64, pix_a};

   always #5 clk = ~clk;

   logic        va, vb, vc, la, lb, lc;
   logic [71:0] win_a, win_b;
   logic [215:0] win_c;
   logic [1:0]  ax, ay, cx, cy;
   logic [0:0]  bx, by;

   line_buffer_mc_stride #(.I_F_BW(8), .CH(1), .IX(6), .IY(6), .KX(3), .KY(3), .STRIDE(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .i_in_valid(in_valid), .i_sof(sof), .i_in_pixel(pix_a),
      .o_window_valid(va), .o_window(win_a), .o_out_x(ax), .o_out_y(ay), .o_last(la));

   line_buffer_mc_stride #(.I_F_BW(8), .CH(1), .IX(6), .IY(6), .KX(3), .KY(3), .STRIDE(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .i_in_valid(in_valid), .i_sof(sof), .i_in_pixel(pix_a),
      .o_window_valid(vb), .o_window(win_b), .o_out_x(bx), .o_out_y(by), .o_last(lb));

   line_buffer_mc_stride #(.I_F_BW(8), .CH(3), .IX(6), .IY(6), .KX(3), .KY(3), .STRIDE(1)) dut_c (
      .clk(clk), .reset_n(reset_n), .i_in_valid(in_valid), .i_sof(sof), .i_in_pixel(pix_c),
      .o_window_valid(vc), .o_window(win_c), .o_out_x(cx), .o_out_y(cy), .o_last(lc));

   typedef struct {
      int trig;
      int ox;
      int oy;
      bit last;
   } pulse_t;

   int vectors = 0;
   int miscompares = 0;

   int img [6][6];
   int mx = 0, my = 0;
   int strd [3] = '{1, 2, 1};
   int chn  [3] = '{1, 1, 3};
   bit e_v [3];
   bit e_l [3];
   int e_x [3];
   int e_y [3];
   logic [215:0] e_w [3];

   int cnt_a = 0;
   int first_a = -1;
   pulse_t got_b [$];

   function automatic logic [215:0] exp_win(int s, int ch, int ox, int oy);
      logic [215:0] w;
      w = '0;
      for (int wy = 0; wy < 3; wy++)
         for (int wx = 0; wx < 3; wx++)
            for (int c = 0; c < ch; c++)
               w[((wy*3 + wx)*ch + c)*8 +: 8] = 8'(img[oy*s + wy][ox*s + wx] + 64*c);
      return w;
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 3; d++) begin
         e_v[d] = 1'b0; e_l[d] = 1'b0; e_x[d] = 0; e_y[d] = 0; e_w[d] = '0;
      end
      mx = 0; my = 0;
   endtask

   task automatic model_accept(bit sf, int val);
      if (sf) begin mx = 0; my = 0; end
      img[my][mx] = val & 255;
      for (int d = 0; d < 3; d++) begin
         int s, o;
         s = strd[d];
         o = (6 - 3) / s + 1;
         if (mx >= 2 && my >= 2 && (mx - 2) % s == 0 && (my - 2) % s == 0) begin
            e_v[d] = 1'b1;
            e_x[d] = (mx - 2) / s;
            e_y[d] = (my - 2) / s;
            e_l[d] = (e_x[d] == o - 1) && (e_y[d] == o - 1);
            e_w[d] = exp_win(s, chn[d], e_x[d], e_y[d]);
         end else begin
            e_v[d] = 1'b0;
            e_l[d] = 1'b0;
         end
      end
      mx++;
      if (mx == 6) begin
         mx = 0;
         my = (my == 5) ? 0 : my + 1;
      end
   endtask

   task automatic check(string name, int d, logic [215:0] act, logic [215:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp);
      end
   endtask

   task automatic check_dut(int d, logic v, logic l, int x, int y, logic [215:0] w);
      check("valid", d, 216'(v), 216'(e_v[d]));
      check("last",  d, 216'(l), 216'(e_l[d]));
      check("out_x", d, 216'(x), 216'(e_x[d]));
      check("out_y", d, 216'(y), 216'(e_y[d]));
      check("window", d, w, e_w[d]);
   endtask

   task automatic check_all();
      check_dut(0, va, la, int'(ax), int'(ay), 216'(win_a));
      check_dut(1, vb, lb, int'(bx), int'(by), 216'(win_b));
      check_dut(2, vc, lc, int'(cx), int'(cy), win_c);
   endtask

   task automatic step(bit v, bit sf, int val);
      if (v) model_accept(sf, val);
      else for (int d = 0; d < 3; d++) begin e_v[d] = 1'b0; e_l[d] = 1'b0; end
      in_valid = v;
      sof = sf;
      pix_a = 8'(val);
      @(posedge clk);
      #1;
      check_all();
      if (va) begin
         cnt_a++;
         if (first_a < 0) first_a = val;
      end
      if (vb) got_b.push_back('{val, int'(bx), int'(by), lb});
      in_valid = 1'b0;
      sof = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      pulse_t tbl_b [4];
      int first_win [9];
      tbl_b = '{'{14, 0, 0, 1'b0}, '{16, 1, 0, 1'b0}, '{26, 0, 1, 1'b0}, '{28, 1, 1, 1'b1}};
      first_win = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
      model_clear();

      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_all();

      // Frame 1: pixel = y*6+x, continuous valid
      cnt_a = 0;
      got_b.delete();
      for (int n = 0; n < 36; n++) begin
         step(1'b1, 1'b0, n);
         if (n == 14) begin
            for (int e = 0; e < 9; e++) begin
               logic [7:0] el;
               el = win_a[e*8 +: 8];
               check("first_win_elem", 0, 216'(el), 216'(first_win[e]));
            end
            check("first_out_xy", 0, 216'({ax, ay}), 216'(0));
            check("first_c_ch2_22", 2, 216'(win_c[((2*3 + 2)*3 + 2)*8 +: 8]), 216'(142));
         end
         if (n == 35) begin
            check("final_last", 0, 216'(la), 216'(1));
            check("final_out_xy", 0, 216'({ax, ay}), 216'(4'b1111));
            check("final_tl", 0, 216'(win_a[7:0]), 216'(21));
            check("final_br", 0, 216'(win_a[71:64]), 216'(35));
         end
      end
      check("pulses_a", 0, 216'(cnt_a), 216'(16));
      check("pulses_b", 1, 216'(got_b.size()), 216'(4));
      for (int i = 0; i < 4; i++) begin
         if (i < got_b.size()) begin
            check("b_trig", 1, 216'(got_b[i].trig), 216'(tbl_b[i].trig));
            check("b_ox",   1, 216'(got_b[i].ox),   216'(tbl_b[i].ox));
            check("b_oy",   1, 216'(got_b[i].oy),   216'(tbl_b[i].oy));
            check("b_last", 1, 216'(got_b[i].last), 216'(tbl_b[i].last));
         end
      end

      // Same image with ~50% valid gaps
      cnt_a = 0;
      for (int n = 0; n < 36; n++) begin
         while ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, $urandom_range(0, 255));
         step(1'b1, 1'b0, n);
      end
      check("pulses_a_gaps", 0, 216'(cnt_a), 216'(16));

      // Random pixel values with gaps
      for (int n = 0; n < 36; n++) begin
         if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 0);
         step(1'b1, 1'b0, $urandom_range(0, 255));
      end

      // i_sof at pixel 10 of a frame, then a 100-series frame
      for (int n = 0; n < 10; n++) step(1'b1, 1'b0, n);
      cnt_a = 0;
      first_a = -1;
      for (int n = 0; n < 36; n++) step(1'b1, n == 0, 100 + n);
      check("pulses_a_sof", 0, 216'(cnt_a), 216'(16));
      check("first_trig_sof", 0, 216'(first_a), 216'(114));

      // Asynchronous reset mid-frame
      for (int n = 0; n < 20; n++) step(1'b1, 1'b0, 200 + n);
      #3;
      reset_n = 1'b0;
      #1;
      model_clear();
      check_all();
      @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_all();
      cnt_a = 0;
      for (int n = 0; n < 36; n++) step(1'b1, 1'b0, n);
      check("pulses_a_post_reset", 0, 216'(cnt_a), 216'(16));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
